shift_pipe: RTL

- Parametrised, pipelined barrel shifter for the CPU execute stage.
- Performs SLL, SRL, SRA and ROTR on a WIDTH-bit operand by a variable amount.
- Uses a valid/ready handshake on input and output, and carries a destination-register tag alongside each operation.
- One log-shifter level per pipeline stage, so throughput is one operation per cycle when not stalled.

---
 rtl/shift_pkg.sv | 34 +++
 rtl/shift_stage.sv | 80 ++++++++
 rtl/shift_pipe.sv | 99 +++++++++
 3 files changed

// File: rtl/shift_pkg.sv
// Shared definitions for the shift_pipe barrel shifter.
//   SH_*          : operation encodings carried on in_op
//   SH_*_MAX      : widths of the stage payload fields. Every field is sized
//                   for the largest supported configuration (WIDTH 64,
//                   TAG_W 16). Smaller builds use the low bits and keep the
//                   upper bits at zero.
//   stage_pay_t   : everything one pipeline stage hands to the next
//   fill_bit()    : the bit shifted in from the MSB side for right shifts
package shift_pkg;

  localparam logic [1:0] SH_SLL  = 2'b00;
  localparam logic [1:0] SH_SRL  = 2'b01;
  localparam logic [1:0] SH_SRA  = 2'b10;
  localparam logic [1:0] SH_ROTR = 2'b11;

  localparam int SH_DATA_MAX = 64;
  localparam int SH_TAG_MAX  = 16;
  localparam int SH_AMT_MAX  = 6;

  typedef struct packed {
    logic [SH_DATA_MAX-1:0] data;
    logic [1:0]             op;
    logic [SH_AMT_MAX-1:0]  amt;
    logic [SH_TAG_MAX-1:0]  tag;
    logic                   fill;
    logic                   carry;
  } stage_pay_t;

  // SRA replicates the operand sign; every other op shifts in zeros.
  function automatic logic fill_bit(input logic [1:0] op, input logic msb);
    return (op == SH_SRA) ? msb : 1'b0;
  endfunction

endpackage

// File: rtl/shift_stage.sv
// One level of the logarithmic shifter plus its pipeline register.
// Stage K shifts by 2**K when amount bit K is set. Otherwise it passes the
// payload through unchanged. The register holds while 'hold' is high.
//   clk, rst   : clock, asynchronous active-high reset
//   hold       : pipeline stall, so every field keeps its value
//   src_valid  : valid bit of the incoming payload
//   src        : payload from the previous stage (or from the pipe input)
//   dst_valid  : registered valid bit
//   dst        : registered payload
// Optional: SHIFT_PIPE_CARRY_EN makes the stage track the last bit shifted out.
module shift_stage
  import shift_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int K     = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       hold,
  input  logic       src_valid,
  input  stage_pay_t src,
  output logic       dst_valid,
  output stage_pay_t dst
);

  localparam int S = 1 << K;

  logic [WIDTH-1:0] cur;
  logic [WIDTH-1:0] shifted;
  logic             take;
  logic             carry_bit;
  stage_pay_t       nxt;

  always_comb begin
    cur       = src.data[WIDTH-1:0];
    take      = src.amt[K];
    shifted   = cur;
    carry_bit = 1'b0;
    case (src.op)
      SH_SLL: begin
        shifted   = {cur[WIDTH-S-1:0], {S{1'b0}}};
        carry_bit = cur[WIDTH-S];
      end
      SH_SRL, SH_SRA: begin
        shifted   = {{S{src.fill}}, cur[WIDTH-1:S]};
        carry_bit = cur[S-1];
      end
      default: begin
        // Rotate: the low S bits wrap into the top. The carry is the new MSB.
        shifted   = {cur[S-1:0], cur[WIDTH-1:S]};
        carry_bit = cur[S-1];
      end
    endcase

    nxt = src;
    if (take) nxt.data = SH_DATA_MAX'(shifted);
`ifdef SHIFT_PIPE_CARRY_EN
    if (take) nxt.carry = carry_bit;
`else
    nxt.carry = 1'b0;
`endif
  end

`ifndef SHIFT_PIPE_CARRY_EN
  logic unused_carry;
  assign unused_carry = carry_bit;
`endif

  // ---- stage register ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dst_valid <= 1'b0;
      dst       <= '0;
    end else if (!hold) begin
      dst_valid <= src_valid;
      dst       <= nxt;
    end
  end

endmodule

// File: rtl/shift_pipe.sv
// Pipelined barrel shifter (SLL / SRL / SRA / ROTR) for the execute stage.
// The pipe has one log-shifter level per stage and $clog2(WIDTH) stages.
// Both ends use a valid/ready handshake, and the whole pipe freezes while
// the output is stalled. Bubbles stay in place and are not collapsed.
//   clk, rst    : clock, asynchronous active-high reset
//   in_valid    : operation presented
//   in_ready    : operation accepted this cycle (low only on output stall)
//   in_op       : 00 SLL, 01 SRL, 10 SRA, 11 ROTR
//   in_amt      : shift amount. Only the low $clog2(WIDTH) bits are used, so
//                 larger amounts wrap modulo WIDTH.
//   in_data     : operand
//   in_tag      : destination tag, passed through unchanged
//   out_valid   : result present
//   out_ready   : consumer takes the result
//   out_data    : result
//   out_tag     : tag of the result
//   out_carry   : last bit shifted out (only with SHIFT_PIPE_CARRY_EN)
module shift_pipe
  import shift_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_op,
  input  logic [WIDTH-1:0] in_amt,
  input  logic [WIDTH-1:0] in_data,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [TAG_W-1:0] out_tag
`ifdef SHIFT_PIPE_CARRY_EN
  ,
  output logic             out_carry
`endif
);

  localparam int SHW = $clog2(WIDTH);

  logic       stall;
  stage_pay_t head;
  stage_pay_t pay [SHW];
  logic       vld [SHW];

  assign stall    = out_valid & ~out_ready;
  assign in_ready = ~stall;

  // The SRA fill bit is captured here, once, from the original operand MSB.
  always_comb begin
    head      = '0;
    head.data = SH_DATA_MAX'(in_data);
    head.op   = in_op;
    head.amt  = SH_AMT_MAX'(in_amt[SHW-1:0]);
    head.tag  = SH_TAG_MAX'(in_tag);
    head.fill = fill_bit(in_op, in_data[WIDTH-1]);
  end

  // ---- stage 0 .. SHW-1 ----
  for (genvar k = 0; k < SHW; k++) begin : g_stage
    if (k == 0) begin : g_first
      shift_stage #(.WIDTH(WIDTH), .K(k)) u_stage (
        .clk       (clk),
        .rst       (rst),
        .hold      (stall),
        .src_valid (in_valid),
        .src       (head),
        .dst_valid (vld[k]),
        .dst       (pay[k])
      );
    end else begin : g_next
      shift_stage #(.WIDTH(WIDTH), .K(k)) u_stage (
        .clk       (clk),
        .rst       (rst),
        .hold      (stall),
        .src_valid (vld[k-1]),
        .src       (pay[k-1]),
        .dst_valid (vld[k]),
        .dst       (pay[k])
      );
    end
  end

  assign out_valid = vld[SHW-1];
  assign out_data  = pay[SHW-1].data[WIDTH-1:0];
  assign out_tag   = pay[SHW-1].tag[TAG_W-1:0];
`ifdef SHIFT_PIPE_CARRY_EN
  assign out_carry = pay[SHW-1].carry;
`endif

  // The amount bits above SHW are ignored. The last stage's op, amount,
  // fill and padding bits have no consumer.
  logic unused_bits;
  assign unused_bits = ^{in_amt[WIDTH-1:SHW], pay[SHW-1]};

endmodule
